// File: rtl/lsu_uart_pkg.sv
// Shared definitions for both ends of the LSU UART link.
// Holds the frame command bytes, the acknowledge byte, the responder
// state encoding and a small command-decode helper. The LSU imports the
// same package, so both sides agree on the frame format.
package lsu_uart_pkg;

    localparam logic [7:0] CMD_LOAD  = 8'h01;
    localparam logic [7:0] CMD_STORE = 8'h02;
    localparam logic [7:0] ACK_BYTE  = 8'hAA;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_DHI      = 4'd2,
        ST_DLO      = 4'd3,
        ST_WRITE    = 4'd4,
        ST_SEND_HI  = 4'd5,
        ST_WAIT_HI  = 4'd6,
        ST_SEND_LO  = 4'd7,
        ST_WAIT_LO  = 4'd8,
        ST_SEND_ACK = 4'd9,
        ST_WAIT_ACK = 4'd10
    } resp_state_t;

    // True for the two command bytes that may open a frame.
    function automatic logic is_valid_cmd(input logic [7:0] b);
        return (b == CMD_LOAD) || (b == CMD_STORE);
    endfunction

endpackage

// File: rtl/lsu_mem_responder_if.sv
// Byte-level link between the UART transceiver / preload source and the
// memory responder.
//   rx_data/rx_done : received byte and its one-cycle strobe
//   tx_done         : transmitter finished the current byte
//   tx_en/tx_data   : start-transmit pulse and the byte to send
//   init_*          : preload write port (honoured only while idle)
//   busy/frame_err  : responder status
// The master modport is the UART/boot side, the slave modport the responder.
interface lsu_mem_responder_if;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        tx_done;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        init_en;
    logic [7:0]  init_addr;
    logic [15:0] init_data;
    logic        busy;
    logic        frame_err;

    modport master (
        output rx_data, rx_done, tx_done, init_en, init_addr, init_data,
        input  tx_en, tx_data, busy, frame_err
    );

    modport slave (
        input  rx_data, rx_done, tx_done, init_en, init_addr, init_data,
        output tx_en, tx_data, busy, frame_err
    );
endinterface

// File: rtl/data_mem_256x16.sv
// 256 x 16 data memory: one synchronous write port, one asynchronous read
// port. Contents have no reset, so data survives a responder reset.
//   clk   : clock
//   we    : write enable, write happens at the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data
module data_mem_256x16 (
    input  logic        clk,
    input  logic        we,
    input  logic [7:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [7:0]  raddr,
    output logic [15:0] rdata
);

    logic [15:0] mem_r [256];

    // Single write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/lsu_mem_responder.sv
// UART-side data-memory responder for the LSU. Parses LOAD/STORE frames
// arriving one byte at a time, services them against a 256 x 16 memory and
// returns response bytes through the transmitter handshake.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : byte link (slave side), see lsu_mem_responder_if
// TIMEOUT_CYCLES bounds the silence allowed between bytes of one frame.
module lsu_mem_responder
    import lsu_uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    lsu_mem_responder_if.slave   bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    resp_state_t      state_r;
    logic             is_load_r;
    logic [7:0]       addr_r;
    logic [7:0]       dhi_r;
    logic [7:0]       dlo_r;
    logic [CNT_W-1:0] cnt_r;
    logic             tx_en_r;
    logic [7:0]       tx_data_r;
    logic             busy_r;
    logic             frame_err_r;

    logic             timeout_s;
    logic [7:0]       rd_addr_s;
    logic [15:0]      rd_data_s;
    logic             mem_we_s;
    logic [7:0]       mem_waddr_s;
    logic [15:0]      mem_wdata_s;

    assign timeout_s = (cnt_r == CNT_LAST);

    // Read address: the address byte is still on rx_data when a load is
    // accepted, so the high byte can be registered in that same cycle.
    always_comb begin
        rd_addr_s = addr_r;
        if (state_r == ST_ADDR) begin
            rd_addr_s = bus.rx_data;
        end else begin
            rd_addr_s = addr_r;
        end
    end

    // Single write port shared by protocol stores and idle-time preload.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = addr_r;
        mem_wdata_s = {dhi_r, dlo_r};
        if (state_r == ST_WRITE) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = addr_r;
            mem_wdata_s = {dhi_r, dlo_r};
        end else if (bus.init_en && (state_r == ST_IDLE)) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = bus.init_addr;
            mem_wdata_s = bus.init_data;
        end else begin
            mem_we_s    = 1'b0;
            mem_waddr_s = addr_r;
            mem_wdata_s = {dhi_r, dlo_r};
        end
    end

    data_mem_256x16 u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (mem_waddr_s),
        .wdata (mem_wdata_s),
        .raddr (rd_addr_s),
        .rdata (rd_data_s)
    );

    // Frame FSM with timeout counter, byte latches and registered outputs.
    // tx_en and frame_err default low so they only ever pulse for one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            is_load_r   <= 1'b0;
            addr_r      <= 8'h00;
            dhi_r       <= 8'h00;
            dlo_r       <= 8'h00;
            cnt_r       <= '0;
            tx_en_r     <= 1'b0;
            tx_data_r   <= 8'h00;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            tx_en_r     <= 1'b0;
            frame_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (bus.rx_done) begin
                        if (is_valid_cmd(bus.rx_data)) begin
                            is_load_r <= (bus.rx_data == CMD_LOAD);
                            state_r   <= ST_ADDR;
                            busy_r    <= 1'b1;
                        end else begin
                            frame_err_r <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (bus.rx_done) begin
                        cnt_r  <= '0;
                        addr_r <= bus.rx_data;
                        if (is_load_r) begin
                            state_r   <= ST_SEND_HI;
                            tx_en_r   <= 1'b1;
                            tx_data_r <= rd_data_s[15:8];
                        end else begin
                            state_r <= ST_DHI;
                        end
                    end else if (timeout_s) begin
                        cnt_r       <= '0;
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                        frame_err_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DHI: begin
                    if (bus.rx_done) begin
                        cnt_r   <= '0;
                        dhi_r   <= bus.rx_data;
                        state_r <= ST_DLO;
                    end else if (timeout_s) begin
                        cnt_r       <= '0;
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                        frame_err_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DLO: begin
                    if (bus.rx_done) begin
                        cnt_r   <= '0;
                        dlo_r   <= bus.rx_data;
                        state_r <= ST_WRITE;
                    end else if (timeout_s) begin
                        cnt_r       <= '0;
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                        frame_err_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_WRITE: begin
                    // Memory write happens this cycle via mem_we_s.
                    state_r   <= ST_SEND_ACK;
                    tx_en_r   <= 1'b1;
                    tx_data_r <= ACK_BYTE;
                end
                ST_SEND_HI: begin
                    state_r <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (bus.tx_done) begin
                        state_r   <= ST_SEND_LO;
                        tx_en_r   <= 1'b1;
                        tx_data_r <= rd_data_s[7:0];
                    end
                end
                ST_SEND_LO: begin
                    state_r <= ST_WAIT_LO;
                end
                ST_WAIT_LO: begin
                    if (bus.tx_done) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_SEND_ACK: begin
                    state_r <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (bus.tx_done) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign bus.tx_en     = tx_en_r;
    assign bus.tx_data   = tx_data_r;
    assign bus.busy      = busy_r;
    assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench for lsu_mem_responder. Inputs change on the falling edge,
// outputs are sampled on the falling edge after the capturing rising edge.
module tb_lsu_mem_responder;
    import lsu_uart_pkg::*;

    localparam int unsigned T_CYC = 1000;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    lsu_mem_responder_if bus ();

    lsu_mem_responder #(.TIMEOUT_CYCLES(T_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        @(negedge clk);
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
    endtask

    task automatic pulse_tx_done();
        @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.init_en   = 1'b1;
        bus.init_addr = a;
        bus.init_data = d;
        @(negedge clk);
        bus.init_en   = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] a, input logic [15:0] exp, input string tag);
        send_byte(CMD_LOAD);
        check({tag, "_busy_cmd"}, {15'd0, bus.busy}, 16'd1);
        check({tag, "_noen_cmd"}, {15'd0, bus.tx_en}, 16'd0);
        send_byte(a);
        check({tag, "_en_hi"}, {15'd0, bus.tx_en}, 16'd1);
        check({tag, "_hi"}, {8'd0, bus.tx_data}, {8'd0, exp[15:8]});
        @(negedge clk);
        check({tag, "_en_hi_drop"}, {15'd0, bus.tx_en}, 16'd0);
        repeat (2) @(negedge clk);
        check({tag, "_hi_hold"}, {8'd0, bus.tx_data}, {8'd0, exp[15:8]});
        pulse_tx_done();
        check({tag, "_en_lo"}, {15'd0, bus.tx_en}, 16'd1);
        check({tag, "_lo"}, {8'd0, bus.tx_data}, {8'd0, exp[7:0]});
        @(negedge clk);
        check({tag, "_busy_lo"}, {15'd0, bus.busy}, 16'd1);
        pulse_tx_done();
        check({tag, "_busy_end"}, {15'd0, bus.busy}, 16'd0);
        check({tag, "_en_end"}, {15'd0, bus.tx_en}, 16'd0);
    endtask

    task automatic do_store(input logic [7:0] a, input logic [15:0] d, input string tag);
        send_byte(CMD_STORE);
        send_byte(a);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
        check({tag, "_write_noen"}, {15'd0, bus.tx_en}, 16'd0);
        @(negedge clk);
        check({tag, "_ack_en"}, {15'd0, bus.tx_en}, 16'd1);
        check({tag, "_ack"}, {8'd0, bus.tx_data}, 16'h00AA);
        pulse_tx_done();
        check({tag, "_busy_end"}, {15'd0, bus.busy}, 16'd0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        bus.rx_data   = 8'h00;
        bus.rx_done   = 1'b0;
        bus.tx_done   = 1'b0;
        bus.init_en   = 1'b0;
        bus.init_addr = 8'h00;
        bus.init_data = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_tx_en", {15'd0, bus.tx_en}, 16'd0);
        check("rst_tx_data", {8'd0, bus.tx_data}, 16'd0);
        check("rst_busy", {15'd0, bus.busy}, 16'd0);
        check("rst_frame_err", {15'd0, bus.frame_err}, 16'd0);
        reset = 1'b1;

        // Basic preload and load.
        preload(8'h10, 16'hBEEF);
        do_load(8'h10, 16'hBEEF, "load_beef");

        // Store then read back.
        do_store(8'h20, 16'h1234, "store_20");
        do_load(8'h20, 16'h1234, "load_20");

        // Unknown command in IDLE.
        send_byte(8'h7F);
        check("bad_cmd_err", {15'd0, bus.frame_err}, 16'd1);
        check("bad_cmd_busy", {15'd0, bus.busy}, 16'd0);
        check("bad_cmd_noen", {15'd0, bus.tx_en}, 16'd0);
        @(negedge clk);
        check("bad_cmd_err_pulse", {15'd0, bus.frame_err}, 16'd0);

        // Inter-byte timeout during a store: exactly T_CYC idle cycles.
        preload(8'h30, 16'h0F0F);
        send_byte(CMD_STORE);
        send_byte(8'h30);
        send_byte(8'h55);
        repeat (T_CYC - 1) @(negedge clk);
        check("to_not_yet_err", {15'd0, bus.frame_err}, 16'd0);
        check("to_not_yet_busy", {15'd0, bus.busy}, 16'd1);
        @(negedge clk);
        check("to_err", {15'd0, bus.frame_err}, 16'd1);
        check("to_busy", {15'd0, bus.busy}, 16'd0);
        @(negedge clk);
        check("to_err_pulse", {15'd0, bus.frame_err}, 16'd0);
        do_load(8'h30, 16'h0F0F, "to_mem_kept");

        // Reset during WAIT_HI aborts the response.
        send_byte(CMD_LOAD);
        send_byte(8'h10);
        check("rst_mid_hi", {8'd0, bus.tx_data}, 16'h00BE);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_tx_en", {15'd0, bus.tx_en}, 16'd0);
        check("rst_mid_tx_data", {8'd0, bus.tx_data}, 16'd0);
        check("rst_mid_busy", {15'd0, bus.busy}, 16'd0);
        reset = 1'b1;
        do_load(8'h10, 16'hBEEF, "after_rst");

        // Stray byte while waiting on the transmitter is dropped.
        send_byte(CMD_LOAD);
        send_byte(8'h20);
        send_byte(8'h7F);
        check("drop_no_err", {15'd0, bus.frame_err}, 16'd0);
        check("drop_busy", {15'd0, bus.busy}, 16'd1);
        pulse_tx_done();
        check("drop_lo", {8'd0, bus.tx_data}, 16'h0034);
        pulse_tx_done();
        check("drop_end", {15'd0, bus.busy}, 16'd0);

        // Preload ignored while busy, honoured in IDLE.
        preload(8'h40, 16'h1111);
        send_byte(CMD_STORE);
        preload(8'h40, 16'h2222);
        send_byte(8'h41);
        send_byte(8'h00);
        send_byte(8'h01);
        @(negedge clk);
        pulse_tx_done();
        check("init_busy_done", {15'd0, bus.busy}, 16'd0);
        do_load(8'h40, 16'h1111, "init_ignored");
        do_load(8'h41, 16'h0001, "store_41");
        preload(8'h40, 16'h3333);
        do_load(8'h40, 16'h3333, "init_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem_responder.md
# lsu_mem_responder

UART-side data-memory responder for the bitty load/store unit. It receives LSU request frames byte-by-byte from a UART receiver, services loads and stores against a 256 x 16 data memory, and returns response bytes through a UART transmitter. It is the far end of the LSU's UART link and serves as the system data memory on FPGA builds and in system-level benches.

## Interface
- TIMEOUT_CYCLES, 1000: maximum idle cycles between bytes of one request frame before the frame is abandoned.
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-low reset.
- rx_data  input  8  received byte; valid only while rx_done = 1.
- rx_done  input  1  one-cycle pulse: new byte on rx_data.
- tx_done  input  1  one-cycle pulse: transmitter has finished the current byte.
- tx_en  output  1  one-cycle pulse: start transmitting tx_data.
- tx_data  output  8  byte to transmit; held stable from the tx_en cycle until tx_done.
- init_en  input  1  bench/boot preload write strobe.
- init_addr  input  8  preload address.
- init_data  input  16  preload data.
- busy  output  1  high in every state except IDLE.
- frame_err  output  1  one-cycle pulse on an unknown command or an inter-byte timeout.

## Operation
- Frame formats (bytes in order): LOAD = 0x01, addr. STORE = 0x02, addr, data[15:8], data[7:0].
- Responses: LOAD returns mem[addr][15:8], then mem[addr][7:0]. STORE returns the single ack byte 0xAA after the write.
- States: IDLE, ADDR, DHI, DLO, WRITE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, SEND_ACK, WAIT_ACK.
- Transitions:
  - IDLE -> ADDR on rx_done with 0x01 or 0x02; the command is latched.
  - IDLE: any other byte pulses frame_err and stays in IDLE.
  - ADDR -> SEND_HI (load) or DHI (store).
  - DHI -> DLO -> WRITE, each on rx_done.
  - WRITE -> SEND_ACK.
  - SEND_x -> WAIT_x unconditionally.
  - WAIT_HI -> SEND_LO, WAIT_LO -> IDLE, WAIT_ACK -> IDLE, each on tx_done.
- Timeout counter: cleared on every accepted byte. In ADDR, DHI and DLO, reaching TIMEOUT_CYCLES cycles without rx_done returns the FSM to IDLE and pulses frame_err. No memory write occurs.
- rx_done outside IDLE/ADDR/DHI/DLO is dropped silently. The host must not send the next frame before the response completes.
- tx_done outside the WAIT_x states is ignored.
- Address is 8 bits, so there is no wrap logic. Data is a full 16 bits, stored as {hi, lo}.
- Preload: init_en writes mem[init_addr] = init_data only in IDLE. It is ignored in all other states.
- Reset: FSM to IDLE; tx_en = 0, tx_data = 0x00, busy = 0, frame_err = 0, timeout counter = 0. Memory contents are unaffected by reset.
- Reset asserted mid-frame or mid-response aborts the frame. No write occurs unless WRITE was already reached.

## Timing
- Byte capture: a byte is accepted in the same cycle rx_done is high. The state advances at that clock edge.
- Load latency: address byte accepted in cycle N; SEND_HI in N+1 drives tx_en = 1 with tx_data = high byte.
  - tx_done in cycle M puts the FSM in SEND_LO at M+1: tx_en pulse with the low byte.
  - tx_done for the low byte in cycle K puts the FSM in IDLE at K+1.
- Store latency: data_lo accepted in cycle N; WRITE in N+1, with memory updated at the end of N+1.
  - SEND_ACK in N+2: tx_en pulse with 0xAA.
  - A load of the same address in a later frame returns the new value.
- tx_data changes only in SEND_x cycles.
- busy rises the cycle after the command byte is accepted and falls on the return to IDLE.

## Structure
- Shared package lsu_uart_pkg holds:
  - command constants CMD_LOAD = 8'h01, CMD_STORE = 8'h02, ACK_BYTE = 8'hAA;
  - the responder state enum.
- The LSU uses the same package so both ends agree on the frame format.
- Sub-module data_mem_256x16 contains the memory. It is a synchronous-write, asynchronous-read register array with one write port, muxed between preload and protocol writes.
- FSM, timeout counter and byte latches live in lsu_mem_responder.

## Test plan
- Preload mem[0x10] = 0xBEEF; send 0x01, 0x10 -> tx_en pulses twice, with tx_data 0xBE then 0xEF after tx_done; busy falls the cycle after the second tx_done.
- Send 0x02, 0x20, 0x12, 0x34 -> ack byte 0xAA; a following load of 0x20 returns 0x12, 0x34.
- Send 0x7F in IDLE -> one-cycle frame_err, no tx_en, busy stays 0.
- Send 0x02, 0x30, 0x55, then silence for TIMEOUT_CYCLES -> frame_err, return to IDLE, mem[0x30] unchanged.
- Assert reset during WAIT_HI of a load -> next cycle tx_en = 0, tx_data = 0x00, busy = 0; a fresh load completes normally.
- Pulse init_en while busy -> memory unchanged; pulse init_en in IDLE -> write visible to a subsequent load.
